example_04: RTL and testbench
=============================

Name: example_04

Overview:
- 8-bit registered data unit; `Q` is updated once per rising `clk` edge.
- Three control bits `{A,B,C}` select one of eight operations on `Q`.
- `D` supplies the 4-bit operand (nibble data, addend, shift-in bits or rotate amount).
- Standalone small datapath, used as a generic register/ALU cell.

Parameters:
none (data width fixed at 8, operand width fixed at 4)

Ports:
- clk   input   1  rising-edge clock, single clock domain
- rstN  input   1  synchronous active-low reset
- A     input   1  operation select, bit 2 (MSB)
- B     input   1  operation select, bit 1
- C     input   1  operation select, bit 0 (LSB)
- D     input   4  operand
- Q     output  8  registered result

Behaviour:
- Only state is the 8-bit register `Q`; the output is driven directly from the flop with no combinational path from inputs.
- Reset:
  - `rstN`=0 sampled at a rising `clk` edge sets `Q`=8'h00.
  - Reset has priority over every operation.
  - Reset is synchronous: `Q` does not change on `rstN` alone, only at the edge.
  - Reset asserted mid-sequence discards the operation of that cycle.
- With `rstN`=1, at each rising edge, op = {A,B,C}:
  - 000 hold: `Q` unchanged.
  - 001 load low nibble: `Q[3:0]`<=`D`, `Q[7:4]` unchanged.
  - 010 load high nibble: `Q[7:4]`<=`D`, `Q[3:0]` unchanged.
  - 011 shift left: `Q`<={`Q[6:0]`,`D[0]`}; `Q[7]` is discarded.
  - 100 increment: `Q`<=`Q`+1 mod 256 (8'hFF wraps to 8'h00, no carry out).
  - 101 add: `Q`<=`Q`+{4'b0,`D`} mod 256; carry is discarded.
  - 110 shift right: `Q`<={`D[3]`,`Q[7:1]`}; `Q[0]` is discarded.
  - 111 rotate left by `D[2:0]` positions (0..7): bits leaving `Q[7]` re-enter at `Q[0]`; `D[3]` is ignored; amount 0 leaves `Q` unchanged.
- Latency: one cycle. Inputs sampled at edge n are reflected on `Q` after edge n.
- Inputs may change at any time between edges; only values at the edge matter.
- No handshake and no status outputs; every enabled cycle performs exactly one operation.
- All arithmetic is unsigned 8-bit.
- X on inputs need not be handled.

Test Plan:
1. Reset: `rstN`=0 for one edge with any `Q` content, `{A,B,C}`=111, `D`=4'h5 -> `Q`=8'h00 after that edge. Release `rstN`, then `{A,B,C}`=111, `D`=0 for 2 edges -> `Q` stays 8'h00.
2. Hold/add/rotate sequence from `Q`=00:
   - `{A,B,C}`=000, `D`=2, 1 edge -> 00.
   - 101, `D`=2, 1 edge -> 02.
   - 111, `D`=2 -> 08.
   - 111, `D`=8 (rotate 0), 2 edges -> 08, 08.
   - 111, `D`=2 -> 20.
3. Nibble loads:
   - 001 with `D`=A -> 0A.
   - 010 with `D`=5 -> 5A.
   - 001 with `D`=3 -> 53.
4. Shifts from 8'h81:
   - 011 with `D`=1 -> 03.
   - 110 with `D`=8 -> 81.
   - 110 with `D`=0 -> 40.
5. Wrap-around:
   - From FF, 100 -> 00.
   - From FE, 101 with `D`=F -> 0D.
   - From 81, 111 with `D`=7 -> C0; with `D`=F (`D[3]` ignored) -> C0 rotated 7 = 60.
6. Mid-operation reset: run 100 from 7F; assert `rstN`=0 at the next edge -> 00, not 80; deassert with 100 -> 01.

Source files
------------

// File: rtl/example_04.sv
// 8-bit registered register/ALU cell: {A,B,C} picks one of eight operations on Q,
// with D as the 4-bit operand. Q is the flop output directly.
module example_04 (
    input  logic       clk,
    input  logic       rstN,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic [3:0] D,
    output logic [7:0] Q
);

    logic [2:0]  op;
    logic [7:0]  q_q;
    logic [7:0]  q_d;
    logic [15:0] rot_w;

    assign op = {A, B, C};

    // Rotate via a doubled copy: the upper byte after shifting is the rotated value.
    assign rot_w = {q_q, q_q} << D[2:0];

    always_comb begin
        q_d = q_q;
        unique case (op)
            3'b000: q_d = q_q;
            3'b001: q_d = {q_q[7:4], D};
            3'b010: q_d = {D, q_q[3:0]};
            3'b011: q_d = {q_q[6:0], D[0]};
            3'b100: q_d = q_q + 8'd1;
            3'b101: q_d = q_q + {4'b0000, D};
            3'b110: q_d = {D[3], q_q[7:1]};
            3'b111: q_d = rot_w[15:8];
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_example_04.sv
// Scoreboard bench for example_04: the driver pushes hand-computed expected Q values,
// a monitor pops and compares one per clock edge.
module tb_example_04;

    logic       clk;
    logic       rstN;
    logic       A;
    logic       B;
    logic       C;
    logic [3:0] D;
    logic [7:0] Q;

    logic [7:0] exp_q[$];
    int         id_q[$];
    int         pass_cnt;
    int         total_cnt;
    int         step;

    example_04 dut (
        .clk (clk),
        .rstN(rstN),
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D),
        .Q   (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector after a falling edge; its result is expected after the next rising edge.
    task automatic apply(input logic rst_n, input logic [2:0] op, input logic [3:0] d,
                         input logic [7:0] exp_val);
        @(negedge clk);
        rstN = rst_n;
        {A, B, C} = op;
        D = d;
        exp_q.push_back(exp_val);
        id_q.push_back(step);
        step++;
    endtask

    always @(posedge clk) begin
        logic [7:0] e;
        int         id;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            total_cnt++;
            if (Q === e) begin
                pass_cnt++;
            end else begin
                $display("FAIL q_step%0d: got Q=%h expected %h", id, Q, e);
            end
        end
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        step      = 0;
        rstN      = 1'b0;
        {A, B, C} = 3'b000;
        D         = 4'h0;

        // Reset from an arbitrary loaded value
        apply(1'b0, 3'b000, 4'h0, 8'h00);
        apply(1'b1, 3'b001, 4'h5, 8'h05);
        apply(1'b1, 3'b010, 4'h3, 8'h35);
        apply(1'b0, 3'b111, 4'h5, 8'h00);
        apply(1'b1, 3'b111, 4'h0, 8'h00);
        apply(1'b1, 3'b111, 4'h0, 8'h00);

        // Hold / add / rotate
        apply(1'b1, 3'b000, 4'h2, 8'h00);
        apply(1'b1, 3'b101, 4'h2, 8'h02);
        apply(1'b1, 3'b111, 4'h2, 8'h08);
        apply(1'b1, 3'b111, 4'h8, 8'h08);
        apply(1'b1, 3'b111, 4'h8, 8'h08);
        apply(1'b1, 3'b111, 4'h2, 8'h20);

        // Nibble loads
        apply(1'b1, 3'b010, 4'h0, 8'h00);
        apply(1'b1, 3'b001, 4'hA, 8'h0A);
        apply(1'b1, 3'b010, 4'h5, 8'h5A);
        apply(1'b1, 3'b001, 4'h3, 8'h53);

        // Shifts from 81
        apply(1'b1, 3'b010, 4'h8, 8'h83);
        apply(1'b1, 3'b001, 4'h1, 8'h81);
        apply(1'b1, 3'b011, 4'h1, 8'h03);
        apply(1'b1, 3'b110, 4'h8, 8'h81);
        apply(1'b1, 3'b110, 4'h0, 8'h40);

        // Wrap-around
        apply(1'b1, 3'b010, 4'hF, 8'hF0);
        apply(1'b1, 3'b001, 4'hF, 8'hFF);
        apply(1'b1, 3'b100, 4'h0, 8'h00);
        apply(1'b1, 3'b010, 4'hF, 8'hF0);
        apply(1'b1, 3'b001, 4'hE, 8'hFE);
        apply(1'b1, 3'b101, 4'hF, 8'h0D);
        apply(1'b1, 3'b010, 4'h8, 8'h8D);
        apply(1'b1, 3'b001, 4'h1, 8'h81);
        apply(1'b1, 3'b111, 4'h7, 8'hC0);
        apply(1'b1, 3'b111, 4'hF, 8'h60);

        // Mid-operation reset
        apply(1'b1, 3'b010, 4'h7, 8'h70);
        apply(1'b1, 3'b001, 4'hF, 8'h7F);
        apply(1'b1, 3'b100, 4'h0, 8'h80);
        apply(1'b0, 3'b100, 4'h0, 8'h00);
        apply(1'b1, 3'b100, 4'h0, 8'h01);
        apply(1'b1, 3'b101, 4'hF, 8'h10);
        apply(1'b1, 3'b011, 4'h0, 8'h20);

        repeat (3) @(posedge clk);
        #2;
        total_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
